// File: rtl/fadc_conv_seq_pkg.sv
// Shared types and sizing for the flash-ADC conversion sequencer.
package fadc_pkg;

  localparam int NBITS_DEF        = 3;
  localparam int AVG_MAX_LOG2_DEF = 3;
  localparam int T_W              = 4;
  localparam int AVG_CFG_W        = 2;

  typedef enum logic [2:0] {
    IDLE,
    AZ,
    SMP,
    LATCH,
    CAPT,
    DONE
  } state_t;

  function automatic int tw_of(input int nbits);
    return (1 << nbits) - 1;
  endfunction

  function automatic int acc_w_of(input int nbits, input int avg_max_log2);
    return nbits + avg_max_log2;
  endfunction

endpackage

// File: rtl/fadc_conv_seq_if.sv
// Result handshake toward the scan/digital side: averaged code, range flags, valid/ready.
interface fadc_conv_seq_if #(
  parameter int NBITS = 3
);
  logic [NBITS-1:0] res_data;
  logic             res_valid;
  logic             res_ready;
  logic             ovr_flag;
  logic             udr_flag;

  modport master (output res_data, res_valid, ovr_flag, udr_flag, input res_ready);
  modport slave  (input res_data, res_valid, ovr_flag, udr_flag, output res_ready);
endinterface

// File: rtl/fadc_therm_enc.sv
// Bubble-correcting thermometer-to-binary encoder: 3-input majority per bit, then popcount.
module fadc_therm_enc #(
  parameter int NBITS = 3
) (
  input  logic [(1<<NBITS)-2:0] therm,
  output logic [NBITS-1:0]      code
);
  localparam int TW = (1 << NBITS) - 1;

  logic [TW+1:0] ext;
  logic [TW-1:0] corr;

  // ext[0] stands in for the virtual bit below the LSB (1), ext[TW+1] for the one above the MSB (0)
  always_comb begin
    ext  = {1'b0, therm, 1'b1};
    corr = '0;
    code = '0;
    for (int i = 0; i < TW; i++) begin
      corr[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
      code    = code + NBITS'(corr[i]);
    end
  end

endmodule

// File: rtl/fadc_conv_seq.sv
// Flash-ADC conversion sequencer: AZ/SMP/LATCH phasing, capture, 2^k averaging, result handshake.
// Optional range flags are built only when FADC_RANGE_FLAG_EN is defined.
module fadc_conv_seq
  import fadc_pkg::*;
#(
  parameter int NBITS        = NBITS_DEF,
  parameter int AVG_MAX_LOG2 = AVG_MAX_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  conv_req,
  input  logic                  cfg_cont,
  input  logic [AVG_CFG_W-1:0]  cfg_avg_log2,
  input  logic [T_W-1:0]        cfg_t_az,
  input  logic [T_W-1:0]        cfg_t_smp,
  output logic                  cmp_az,
  output logic                  cmp_smp,
  output logic                  cmp_latch,
  input  logic [(1<<NBITS)-2:0] therm_in,
  output logic                  busy,
  fadc_conv_seq_if.master       res
);
  localparam int TW    = (1 << NBITS) - 1;
  localparam int ACC_W = NBITS + AVG_MAX_LOG2;
  localparam int CNT_W = AVG_MAX_LOG2 + 1;
  localparam int AVG_W = $clog2(AVG_MAX_LOG2 + 2);

  function automatic logic [AVG_W-1:0] clamp_avg(input logic [AVG_CFG_W-1:0] a);
    if (int'(a) > AVG_MAX_LOG2) return AVG_W'(AVG_MAX_LOG2);
    return AVG_W'(a);
  endfunction

  function automatic logic [NBITS-1:0] avg_trunc(input logic [ACC_W-1:0] acc_v,
                                                 input logic [AVG_W-1:0] sh);
    logic [ACC_W-1:0] s;
    s = acc_v >> sh;
    return s[NBITS-1:0];
  endfunction

  state_t           state, state_nx;
  logic [T_W-1:0]   tmr;
  logic [T_W-1:0]   sh_taz, sh_tsmp;
  logic [AVG_W-1:0] sh_avg;
  logic [CNT_W-1:0] cnt, n_last;
  logic [ACC_W-1:0] acc, acc_sum;
  logic [NBITS-1:0] code_p0, res_data_q;
  logic             res_valid_q;
  logic             start_ld, capt;

  fadc_therm_enc #(.NBITS(NBITS)) u_enc (
    .therm (therm_in),
    .code  (code_p0)
  );

  // A new run starts from IDLE on request, or straight out of DONE in continuous mode
  assign start_ld = ((state == IDLE) && conv_req) ||
                    ((state == DONE) && res.res_ready && cfg_cont);
  assign capt     = (state == CAPT);
  assign n_last   = CNT_W'((1 << sh_avg) - 1);
  assign acc_sum  = acc + ACC_W'(code_p0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (conv_req) state_nx = AZ;
      AZ:      if (tmr == sh_taz) state_nx = SMP;
      SMP:     if (tmr == sh_tsmp) state_nx = LATCH;
      LATCH:   state_nx = CAPT;
      CAPT:    state_nx = (cnt == n_last) ? DONE : AZ;
      DONE:    if (res.res_ready) state_nx = cfg_cont ? AZ : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change cleanly with the state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tmr         <= '0;
      cmp_az      <= 1'b0;
      cmp_smp     <= 1'b0;
      cmp_latch   <= 1'b0;
      busy        <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state       <= state_nx;
      tmr         <= (state_nx != state) ? '0 : tmr + T_W'(1);
      cmp_az      <= (state_nx == AZ);
      cmp_smp     <= (state_nx == SMP);
      cmp_latch   <= (state_nx == LATCH);
      busy        <= (state_nx != IDLE);
      res_valid_q <= (state_nx == DONE);
    end
  end

  // Capture stage: encoded therm code is summed at the end of CAPT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      cnt        <= '0;
      sh_avg     <= '0;
      sh_taz     <= '0;
      sh_tsmp    <= '0;
      res_data_q <= '0;
    end else if (start_ld) begin
      acc     <= '0;
      cnt     <= '0;
      sh_avg  <= clamp_avg(cfg_avg_log2);
      sh_taz  <= cfg_t_az;
      sh_tsmp <= cfg_t_smp;
    end else if (capt) begin
      acc <= acc_sum;
      cnt <= cnt + CNT_W'(1);
      if (state_nx == DONE) res_data_q <= avg_trunc(acc_sum, sh_avg);
    end
  end

  assign res.res_data  = res_data_q;
  assign res.res_valid = res_valid_q;

`ifdef FADC_RANGE_FLAG_EN
  logic ovr_q, udr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_q <= 1'b0;
      udr_q <= 1'b0;
    end else if (start_ld) begin
      ovr_q <= 1'b0;
      udr_q <= 1'b0;
    end else if (capt) begin
      if (code_p0 == NBITS'(TW)) ovr_q <= 1'b1;
      if (code_p0 == '0)         udr_q <= 1'b1;
    end
  end

  assign res.ovr_flag = ovr_q;
  assign res.udr_flag = udr_q;
`else
  assign res.ovr_flag = 1'b0;
  assign res.udr_flag = 1'b0;
`endif

endmodule

// File: tb/tb_fadc_conv_seq.sv
// Bench for fadc_conv_seq: vector table plus hand-written timing, backpressure/continuous and reset sequences.
module tb_fadc_conv_seq;

`ifdef FADC_RANGE_FLAG_EN
  localparam bit FLAG_EN = 1'b1;
`else
  localparam bit FLAG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       conv_req = 1'b0;
  logic       cfg_cont = 1'b0;
  logic [1:0] cfg_avg_log2 = 2'd0;
  logic [3:0] cfg_t_az = 4'd0;
  logic [3:0] cfg_t_smp = 4'd0;
  logic [6:0] therm_in = 7'd0;
  logic       cmp_az, cmp_smp, cmp_latch, busy;

  fadc_conv_seq_if #(.NBITS(3)) rif ();

  fadc_conv_seq #(.NBITS(3), .AVG_MAX_LOG2(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .conv_req     (conv_req),
    .cfg_cont     (cfg_cont),
    .cfg_avg_log2 (cfg_avg_log2),
    .cfg_t_az     (cfg_t_az),
    .cfg_t_smp    (cfg_t_smp),
    .cmp_az       (cmp_az),
    .cmp_smp      (cmp_smp),
    .cmp_latch    (cmp_latch),
    .therm_in     (therm_in),
    .busy         (busy),
    .res          (rif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0] data;
    logic       ovr;
    logic       udr;
  } exp_t;

  typedef struct packed {
    logic [1:0]      avg;
    logic [3:0]      taz;
    logic [3:0]      tsmp;
    logic [7:0][6:0] th;
    logic [2:0]      data;
    logic            ovr;
    logic            udr;
  } vec_t;

  exp_t       sb[$];
  logic [6:0] therm_q[$];

  function automatic vec_t mk(input logic [1:0] a, input logic [3:0] taz, input logic [3:0] tsmp,
                              input logic [2:0] d, input logic o, input logic u,
                              input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] c2,
                              input logic [6:0] c3, input logic [6:0] c4, input logic [6:0] c5,
                              input logic [6:0] c6, input logic [6:0] c7);
    vec_t v;
    v.avg = a; v.taz = taz; v.tsmp = tsmp; v.data = d; v.ovr = o; v.udr = u;
    v.th[0] = c0; v.th[1] = c1; v.th[2] = c2; v.th[3] = c3;
    v.th[4] = c4; v.th[5] = c5; v.th[6] = c6; v.th[7] = c7;
    return v;
  endfunction

  // Comparator model: therm code appears the cycle after the latch strobe
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_latch) begin
        if (therm_q.size() > 0) therm_in = therm_q.pop_front();
        else therm_in = 7'd0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("phase_excl", int'($onehot0({cmp_az, cmp_smp, cmp_latch})), 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [2:0] d, input logic o, input logic u);
    exp_t e;
    e.data = d;
    e.ovr  = o & FLAG_EN;
    e.udr  = u & FLAG_EN;
    sb.push_back(e);
  endtask

  task automatic start_conv();
    @(negedge clk);
    conv_req = 1'b1;
    @(posedge clk);
    #1;
    conv_req = 1'b0;
  endtask

  task automatic wait_result(input int exp_lat, input string tag);
    int   k;
    exp_t e;
    for (k = 1; k <= 2000; k++) begin
      @(posedge clk);
      #1;
      if (rif.res_valid) break;
    end
    check({tag, "_latency"}, k, exp_lat);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_data"}, int'(rif.res_data), int'(e.data));
      check({tag, "_ovr"}, int'(rif.ovr_flag), int'(e.ovr));
      check({tag, "_udr"}, int'(rif.udr_flag), int'(e.udr));
    end
  endtask

  task automatic handshake(input string tag, input int exp_busy);
    rif.res_ready = 1'b1;
    @(posedge clk);
    #1;
    rif.res_ready = 1'b0;
    check({tag, "_valid_drop"}, int'(rif.res_valid), 0);
    check({tag, "_busy_after"}, int'(busy), exp_busy);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    cfg_avg_log2 = v.avg;
    cfg_t_az     = v.taz;
    cfg_t_smp    = v.tsmp;
    cfg_cont     = 1'b0;
    n = 1 << int'(v.avg);
    for (int j = 0; j < n; j++) therm_q.push_back(v.th[j]);
    push_exp(v.data, v.ovr, v.udr);
    start_conv();
    check({tag, "_flags_clr"}, int'({rif.ovr_flag, rif.udr_flag}), 0);
    wait_result(n * (int'(v.taz) + int'(v.tsmp) + 4), tag);
    handshake(tag, 0);
  endtask

  localparam int NV = 9;
  vec_t vecs[NV];

  initial begin
    rif.res_ready = 1'b0;

    vecs[0] = mk(2'd0, 4'd0, 4'd0, 3'd4, 1'b0, 1'b0, 7'b0010111, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    vecs[1] = mk(2'd0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1, 7'b0000000, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    vecs[2] = mk(2'd0, 4'd1, 4'd0, 3'd7, 1'b1, 1'b0, 7'b1111111, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    vecs[3] = mk(2'd2, 4'd2, 4'd3, 3'd4, 1'b0, 1'b0, 7'b0000111, 7'b0001111, 7'b0001111, 7'b0011111,
                 7'd0, 7'd0, 7'd0, 7'd0);
    vecs[4] = mk(2'd2, 4'd1, 4'd1, 3'd3, 1'b0, 1'b0, 7'b0000111, 7'b0000111, 7'b0000111, 7'b0001111,
                 7'd0, 7'd0, 7'd0, 7'd0);
    vecs[5] = mk(2'd1, 4'd0, 4'd0, 3'd4, 1'b1, 1'b0, 7'b1111111, 7'b0000101, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    vecs[6] = mk(2'd0, 4'd0, 4'd2, 3'd4, 1'b0, 1'b0, 7'b0001111, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    vecs[7] = mk(2'd3, 4'd0, 4'd0, 3'd7, 1'b1, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    vecs[8] = mk(2'd1, 4'd3, 4'd0, 3'd0, 1'b0, 1'b1, 7'b0000000, 7'b0000001, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", int'({cmp_az, cmp_smp, cmp_latch, busy, rif.res_valid}), 0);
    check("rst_data", int'(rif.res_data), 0);
    check("rst_flags", int'({rif.ovr_flag, rif.udr_flag}), 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic phase timing, one cycle per phase
    cfg_avg_log2 = 2'd0; cfg_t_az = 4'd0; cfg_t_smp = 4'd0;
    therm_q.push_back(7'b0001111);
    push_exp(3'd4, 1'b0, 1'b0);
    start_conv();
    check("tim_az", int'({cmp_az, cmp_smp, cmp_latch}), 4);
    check("tim_busy", int'(busy), 1);
    @(posedge clk); #1;
    check("tim_smp", int'({cmp_az, cmp_smp, cmp_latch}), 2);
    @(posedge clk); #1;
    check("tim_latch", int'({cmp_az, cmp_smp, cmp_latch}), 1);
    @(posedge clk); #1;
    check("tim_capt", int'({cmp_az, cmp_smp, cmp_latch, rif.res_valid}), 0);
    wait_result(1, "tim");
    handshake("tim", 0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Backpressure: result held, requests ignored; then continuous restart with reloaded config
    cfg_avg_log2 = 2'd0; cfg_t_az = 4'd0; cfg_t_smp = 4'd0; cfg_cont = 1'b0;
    therm_q.push_back(7'b0011111);
    push_exp(3'd5, 1'b0, 1'b0);
    start_conv();
    wait_result(4, "bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      conv_req = (i % 2 == 0);
      @(posedge clk); #1;
      check("bp_hold", int'({rif.res_valid, busy, rif.res_data}), int'({1'b1, 1'b1, 3'd5}));
    end
    conv_req  = 1'b0;
    cfg_cont  = 1'b1;
    cfg_t_smp = 4'd2;
    therm_q.push_back(7'b0000011);
    push_exp(3'd2, 1'b0, 1'b0);
    handshake("cont", 1);
    check("cont_az", int'(cmp_az), 1);
    wait_result(6, "cont");
    cfg_cont = 1'b0;
    handshake("cont2", 0);

    // Reset asserted mid-sample
    cfg_t_az = 4'd1; cfg_t_smp = 4'd5; cfg_avg_log2 = 2'd0;
    start_conv();
    for (int k = 0; k < 20; k++) begin
      if (cmp_smp) break;
      @(posedge clk); #1;
    end
    check("rst_reach_smp", int'(cmp_smp), 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_cmp", int'({cmp_az, cmp_smp, cmp_latch}), 0);
    check("rst_async_ctl", int'({busy, rif.res_valid, rif.ovr_flag, rif.udr_flag}), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("rst_stay_idle", int'({busy, cmp_az, cmp_smp, cmp_latch}), 0);
    therm_q.delete();

    run_vec(vecs[0], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
